// File: rtl/tile_pkg.sv
// rtl/tile_pkg.sv - shared screen, tile, colour and state definitions for the tile engine
package tile_pkg;

  localparam int TILE_SIZE = 8;
  localparam int SCREEN_W  = 160;
  localparam int SCREEN_H  = 120;
  localparam int X_W       = 8;
  localparam int Y_W       = 7;
  localparam int COLOUR_W  = 3;

  localparam logic [COLOUR_W-1:0] COLOUR_BLACK   = 3'b000;
  localparam logic [COLOUR_W-1:0] COLOUR_BLUE    = 3'b001;
  localparam logic [COLOUR_W-1:0] COLOUR_GREEN   = 3'b010;
  localparam logic [COLOUR_W-1:0] COLOUR_CYAN    = 3'b011;
  localparam logic [COLOUR_W-1:0] COLOUR_RED     = 3'b100;
  localparam logic [COLOUR_W-1:0] COLOUR_MAGENTA = 3'b101;
  localparam logic [COLOUR_W-1:0] COLOUR_YELLOW  = 3'b110;
  localparam logic [COLOUR_W-1:0] COLOUR_WHITE   = 3'b111;

  typedef enum logic [1:0] {IDLE, DRAW, CLEAR, FINISH} state_e;

endpackage

// File: rtl/tile_drawer_raster_counter.sv
// rtl/tile_drawer_raster_counter.sv - 2-D raster counter with runtime limits, cx fastest
module raster_counter #(
  parameter int XW = 8,
  parameter int YW = 7
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          enable,
  input  logic [XW-1:0] xmax,
  input  logic [YW-1:0] ymax,
  output logic [XW-1:0] cx,
  output logic [YW-1:0] cy,
  output logic          last
);

  logic [XW-1:0] cx_q, cx_d;
  logic [YW-1:0] cy_q, cy_d;
  logic          x_end, y_end;

  always_comb begin
    x_end = (cx_q == xmax - XW'(1));
    y_end = (cy_q == ymax - YW'(1));
    cx_d  = cx_q;
    cy_d  = cy_q;
    if (clear) begin
      cx_d = '0;
      cy_d = '0;
    end else if (enable) begin
      if (x_end) begin
        cx_d = '0;
        cy_d = y_end ? '0 : cy_q + YW'(1);
      end else begin
        cx_d = cx_q + XW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cx_q <= '0;
      cy_q <= '0;
    end else begin
      cx_q <= cx_d;
      cy_q <= cy_d;
    end
  end

  assign cx   = cx_q;
  assign cy   = cy_q;
  assign last = x_end && y_end;

endmodule

// File: rtl/tile_drawer.sv
// rtl/tile_drawer.sv - turns a tile-draw or screen-clear command into registered VGA pixel writes
module tile_drawer
  import tile_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                op,
  input  logic [X_W-1:0]      tile_x,
  input  logic [Y_W-1:0]      tile_y,
  input  logic [COLOUR_W-1:0] tile_colour,
  output logic                ready,
  output logic                done,
  output logic [X_W-1:0]      vga_x,
  output logic [Y_W-1:0]      vga_y,
  output logic [COLOUR_W-1:0] vga_colour,
  output logic                vga_plot
);

  state_e                state_q, state_d;
  logic                  op_q, op_d;
  logic [X_W-1:0]        tile_x_q, tile_x_d;
  logic [Y_W-1:0]        tile_y_q, tile_y_d;
  logic [COLOUR_W-1:0]   colour_q, colour_d;
  logic                  ready_q, ready_d;
  logic                  done_q, done_d;
  logic                  plot_q, plot_d;
  logic [X_W-1:0]        vga_x_q, vga_x_d;
  logic [Y_W-1:0]        vga_y_q, vga_y_d;
  logic [COLOUR_W-1:0]   vga_colour_q, vga_colour_d;
  logic                  last_emit_q, last_emit_d;

  logic                  idle, is_clear, on_screen;
  logic [X_W-1:0]        cmd_x, cx, xmax;
  logic [Y_W-1:0]        cmd_y, cy, ymax;
  logic [COLOUR_W-1:0]   cmd_colour;
  logic [X_W:0]          xsum;
  logic [Y_W:0]          ysum;
  logic                  cnt_clear, cnt_en, cnt_last;

  // The counter holds the pixel emitted on the next edge, so outputs stay registered.
  raster_counter #(.XW(X_W), .YW(Y_W)) u_raster (
    .clk    (clk),
    .reset  (reset),
    .clear  (cnt_clear),
    .enable (cnt_en),
    .xmax   (xmax),
    .ymax   (ymax),
    .cx     (cx),
    .cy     (cy),
    .last   (cnt_last)
  );

  always_comb begin
    idle       = (state_q == IDLE);
    is_clear   = idle ? op          : op_q;
    cmd_x      = idle ? tile_x      : tile_x_q;
    cmd_y      = idle ? tile_y      : tile_y_q;
    cmd_colour = idle ? tile_colour : colour_q;
    xmax       = is_clear ? X_W'(SCREEN_W) : X_W'(TILE_SIZE);
    ymax       = is_clear ? Y_W'(SCREEN_H) : Y_W'(TILE_SIZE);
    // Wide sums so off-screen pixels clip instead of wrapping.
    xsum       = {1'b0, cmd_x} + {1'b0, cx};
    ysum       = {1'b0, cmd_y} + {1'b0, cy};
    on_screen  = (xsum < (X_W+1)'(SCREEN_W)) && (ysum < (Y_W+1)'(SCREEN_H));

    state_d      = state_q;
    op_d         = op_q;
    tile_x_d     = tile_x_q;
    tile_y_d     = tile_y_q;
    colour_d     = colour_q;
    ready_d      = 1'b0;
    done_d       = 1'b0;
    plot_d       = 1'b0;
    vga_x_d      = vga_x_q;
    vga_y_d      = vga_y_q;
    vga_colour_d = vga_colour_q;
    last_emit_d  = 1'b0;
    cnt_clear    = 1'b0;
    cnt_en       = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          op_d     = op;
          tile_x_d = tile_x;
          tile_y_d = tile_y;
          colour_d = tile_colour;
          state_d  = op ? CLEAR : DRAW;
          cnt_en   = 1'b1;
        end else begin
          ready_d   = 1'b1;
          cnt_clear = 1'b1;
        end
      end
      DRAW, CLEAR: begin
        if (last_emit_q) begin
          state_d   = FINISH;
          done_d    = 1'b1;
          cnt_clear = 1'b1;
        end else begin
          cnt_en      = 1'b1;
          last_emit_d = cnt_last;
        end
      end
      FINISH: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
    endcase

    if (cnt_en) begin
      vga_x_d      = is_clear ? cx : xsum[X_W-1:0];
      vga_y_d      = is_clear ? cy : ysum[Y_W-1:0];
      vga_colour_d = is_clear ? COLOUR_BLACK : cmd_colour;
      plot_d       = is_clear || on_screen;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      op_q         <= 1'b0;
      tile_x_q     <= '0;
      tile_y_q     <= '0;
      colour_q     <= '0;
      ready_q      <= 1'b1;
      done_q       <= 1'b0;
      plot_q       <= 1'b0;
      vga_x_q      <= '0;
      vga_y_q      <= '0;
      vga_colour_q <= '0;
      last_emit_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      tile_x_q     <= tile_x_d;
      tile_y_q     <= tile_y_d;
      colour_q     <= colour_d;
      ready_q      <= ready_d;
      done_q       <= done_d;
      plot_q       <= plot_d;
      vga_x_q      <= vga_x_d;
      vga_y_q      <= vga_y_d;
      vga_colour_q <= vga_colour_d;
      last_emit_q  <= last_emit_d;
    end
  end

  assign ready      = ready_q;
  assign done       = done_q;
  assign vga_plot   = plot_q;
  assign vga_x      = vga_x_q;
  assign vga_y      = vga_y_q;
  assign vga_colour = vga_colour_q;

endmodule

// File: tb/tb_tile_drawer.sv
// tb/tb_tile_drawer.sv - scoreboard bench for tile_drawer: tile draws, clipping, clear, ignored starts, reset abort
module tb_tile_drawer;

  logic       clk = 1'b0;
  logic       reset, start, op;
  logic [7:0] tile_x;
  logic [6:0] tile_y;
  logic [2:0] tile_colour;
  logic       ready, done, vga_plot;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;

  int checks = 0;
  int errors = 0;
  int plots  = 0;
  int dones  = 0;
  int p0, d0;
  logic [17:0] exp_q[$];
  logic [17:0] e_pix;

  tile_drawer dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .tile_x      (tile_x),
    .tile_y      (tile_y),
    .tile_colour (tile_colour),
    .ready       (ready),
    .done        (done),
    .vga_x       (vga_x),
    .vga_y       (vga_y),
    .vga_colour  (vga_colour),
    .vga_plot    (vga_plot)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done === 1'b1) dones++;
    if (vga_plot === 1'b1) begin
      plots++;
      if (exp_q.size() == 0) begin
        check("unexpected_plot", {14'd0, vga_x, vga_y, vga_colour}, 32'hFFFF_FFFF);
      end else begin
        e_pix = exp_q.pop_front();
        check("pixel", {14'd0, vga_x, vga_y, vga_colour}, {14'd0, e_pix});
      end
    end
  end

  task automatic push_tile(input int x, input int y, input logic [2:0] c);
    for (int j = 0; j < 8; j++)
      for (int i = 0; i < 8; i++) begin
        int px, py;
        px = x + i;
        py = y + j;
        if (px < 160 && py < 120) exp_q.push_back({px[7:0], py[6:0], c});
      end
  endtask

  task automatic push_clear();
    for (int y = 0; y < 120; y++)
      for (int x = 0; x < 160; x++)
        exp_q.push_back({x[7:0], y[6:0], 3'b000});
  endtask

  // Called on a negedge; returns on the negedge of the first pixel cycle.
  task automatic issue(input logic o, input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
    start = 1'b1; op = o; tile_x = x; tile_y = y; tile_colour = c;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n;
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'd0, done}, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; start = 1'b0; op = 1'b0;
    tile_x = '0; tile_y = '0; tile_colour = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", {31'd0, ready}, 32'd1);
    check("rst_plot", {31'd0, vga_plot}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_coords", {14'd0, vga_x, vga_y, vga_colour}, 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_flags", {29'd0, ready, vga_plot, done}, 32'b100);
      check("idle_coords", {14'd0, vga_x, vga_y, vga_colour}, 32'd0);
    end

    // Tile at (8,0): 64 consecutive plots, done in cycle 65, ready in cycle 66.
    p0 = plots; d0 = dones;
    push_tile(8, 0, 3'b010);
    issue(1'b0, 8'd8, 7'd0, 3'b010);
    for (int i = 1; i <= 64; i++) begin
      check("t1_plot", {31'd0, vga_plot}, 32'd1);
      @(negedge clk);
    end
    check("t1_done65", {30'd0, done, ready}, 32'b10);
    check("t1_plot65", {31'd0, vga_plot}, 32'd0);
    @(negedge clk);
    check("t1_ready66", {30'd0, done, ready}, 32'b01);
    check("t1_count", plots - p0, 32'd64);
    check("t1_dones", dones - d0, 32'd1);
    check("t1_queue", exp_q.size(), 32'd0);

    // Clipped tile at (156,116) with ignored starts during DRAW and FINISH.
    @(negedge clk);
    p0 = plots; d0 = dones;
    push_tile(156, 116, 3'b100);
    start = 1'b1; op = 1'b0; tile_x = 8'd156; tile_y = 7'd116; tile_colour = 3'b100;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 1; i <= 66; i++) begin
      @(negedge clk);
      if (i == 10) begin
        check("t2_busy", {31'd0, ready}, 32'd0);
        start = 1'b1; tile_x = 8'd40; tile_y = 7'd40; tile_colour = 3'b111;
      end
      if (i == 11) start = 1'b0;
      if (i == 65) begin
        check("t2_done65", {31'd0, done}, 32'd1);
        check("t2_finish_ready", {31'd0, ready}, 32'd0);
        check("t2_clip_count", plots - p0, 32'd16);
        start = 1'b1; op = 1'b0; tile_x = 8'd0; tile_y = 7'd16; tile_colour = 3'b001;
      end
      if (i == 66) begin
        check("t2_ready66", {31'd0, ready}, 32'd1);
        check("t2_queue", exp_q.size(), 32'd0);
        push_tile(0, 16, 3'b001);
      end
    end
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check("t3_first_plot", {31'd0, vga_plot}, 32'd1);
    check("t2_dones", dones - d0, 32'd1);
    wait_done(80, "t3_done");
    @(negedge clk);
    check("t3_ready", {31'd0, ready}, 32'd1);
    check("t3_queue", exp_q.size(), 32'd0);
    check("t23_count", plots - p0, 32'd80);

    // Full-screen clear.
    p0 = plots; d0 = dones;
    push_clear();
    issue(1'b1, 8'd55, 7'd3, 3'b111);
    wait_done(19300, "clr_done");
    check("clr_count", plots - p0, 32'd19200);
    check("clr_queue", exp_q.size(), 32'd0);
    @(negedge clk);
    check("clr_dones", dones - d0, 32'd1);
    check("clr_ready", {31'd0, ready}, 32'd1);

    // Reset at the 30th pixel abandons the draw; a fresh start redraws all 64.
    p0 = plots; d0 = dones;
    push_tile(24, 32, 3'b011);
    issue(1'b0, 8'd24, 7'd32, 3'b011);
    repeat (29) @(negedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("rst_abort_flags", {29'd0, ready, vga_plot, done}, 32'b100);
    reset = 1'b0;
    check("rst_abort_count", plots - p0, 32'd30);
    exp_q.delete();
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      check("rst_abort_idle", {29'd0, ready, vga_plot, done}, 32'b100);
    end
    check("rst_abort_nodone", dones - d0, 32'd0);
    p0 = plots;
    push_tile(24, 32, 3'b011);
    issue(1'b0, 8'd24, 7'd32, 3'b011);
    wait_done(80, "rst_redo_done");
    check("rst_redo_count", plots - p0, 32'd64);
    check("rst_redo_queue", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
